vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Receive-side counterpart of the VGA timing generator: samples the active-low hsync/vsync and 12-bit rgb stream at pixel rate, recovers pixel coordinates, measures line and frame timing, and declares lock once timing matches the expected 800x600-count raster. It sits in the capture/self-check path, either looped back from the display outputs or fed from an external source, and feeds frame-checksum and overlay-verification logic downstream.

## Interface
- H_TOTAL, 800, expected clocks-per-line (pixel strobes)
- V_TOTAL, 600, expected lines per frame
- H_ACT_START, 96, first active pixel count after hsync falling edge
- H_ACT_LEN, 640, active pixels per line
- V_ACT_START, 2, first active line after vsync falling edge
- V_ACT_LEN, 480, active lines per frame
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  one-cycle pixel strobe; all sampling only when high
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- rgb_in  in  12  pixel colour {R4,G4,B4}
- out_valid  out  1  registered copy of pix_en
- de  out  1  active-area pixel while locked
- px_x  out  10  active-area x (0..H_ACT_LEN-1), 0 when de=0
- px_y  out  10  active-area y (0..V_ACT_LEN-1), 0 when de=0
- rgb_out  out  12  rgb_in captured with this sample
- frame_start  out  1  one-cycle pulse on vsync falling edge
- locked  out  1  FSM in LOCKED
- line_len  out  11  length of last completed line
- frame_lines  out  11  line count of last completed frame
- err_cnt  out  8  saturating count of LOCKED->SEARCH drops

## Operation
- Edge detect: hs_q/vs_q hold the previous sampled sync, updated only on pix_en. Fall = q==1 && input==0. Both reset to 0, so after reset a sync must be seen high before its fall is recognised (no false edge).
- h_cnt (11 b): on hsync fall, h_cnt<=0 and line_len<=h_cnt+1; else +1, saturating at 2047.
- v_cnt (11 b): on vsync fall, v_cnt<=0 and frame_lines<=v_cnt+1 (vsync fall wins over a coincident hsync fall); else on hsync fall +1, saturating at 2047.
- Line error: hsync fall with h_cnt+1 != H_TOTAL, or h_cnt reaching H_TOTAL without hsync fall (overrun, flagged at that sample).
- Frame error: vsync fall with v_cnt+1 != V_TOTAL.
- FSM states: SEARCH, CHECK, LOCKED.
  - SEARCH: all errors ignored; vsync fall -> CHECK.
  - CHECK: any line error -> stay CHECK, clear frame-good flag; vsync fall -> LOCKED if frame-good and no frame error, else CHECK with frame-good set. The hsync fall coincident with the entering vsync fall is not checked; the one coincident with the closing vsync fall is.
  - LOCKED: any line or frame error -> SEARCH, err_cnt+1 (saturate 255).
- de = locked && H_ACT_START<=h_cnt'<H_ACT_START+H_ACT_LEN && V_ACT_START<=v_cnt'<V_ACT_START+V_ACT_LEN, where h_cnt'/v_cnt' are the values after this sample's update. px_x=h_cnt'-H_ACT_START, px_y=v_cnt'-V_ACT_START.

## Timing
- Reset: every output 0, h_cnt=v_cnt=0, state SEARCH, hs_q=vs_q=0. Reset mid-frame aborts lock immediately; err_cnt is cleared, not incremented.
- Latency: sample on pix_en cycle N; out_valid, de, px_x, px_y, rgb_out, frame_start, line_len, frame_lines valid at N+1, held until next pix_en. out_valid and frame_start are single-cycle.
- locked asserts the cycle after the second good vsync fall (end of first fully clean frame); drops the cycle after the offending sample.
- pix_en low: no state change, outputs hold except out_valid/frame_start which go 0.
- Lock acquisition from reset with clean input: 2 vsync falls, i.e. <= 2*H_TOTAL*V_TOTAL strobes.

## Test plan
- Clean raster (800x600, hsync low counts 0..95, vsync low lines 0..1, pix_en every 4th clk) -> locked=1 after second vsync fall; line_len=800, frame_lines=600, err_cnt=0.
- Locked, sample at h=96,v=2 with rgb_in=12'hABC -> next cycle de=1, px_x=0, px_y=0, rgb_out=12'hABC; at h=735,v=481 -> px_x=639, px_y=479; at h=736 -> de=0.
- Locked, one line shortened to 799 -> locked drops the cycle after that hsync fall, err_cnt=1; relock after two further clean frames.
- Locked, hsync held high -> overrun at h_cnt=800 drops lock, err_cnt=1; line_len keeps last value 800.
- Frame of 601 lines in CHECK -> no lock at that vsync fall (frame_lines=601); next clean frame -> locked.
- Reset asserted mid-frame while hsync/vsync low -> all outputs 0 next cycle; no edge recognised until syncs go high then low; err_cnt stays 0.

Source files
------------

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_decoder
// Purpose  : Receive-side VGA timing decoder. Samples active-low hsync/vsync
//            and 12-bit rgb on each pixel strobe, recovers active-area pixel
//            coordinates, measures line/frame lengths and declares lock once
//            the raster matches H_TOTAL x V_TOTAL.
// Ports    : clk, reset (sync, active high), pix_en (pixel strobe),
//            hsync/vsync (active low), rgb_in[11:0]
//            -> out_valid, de, px_x[9:0], px_y[9:0], rgb_out[11:0],
//               frame_start, locked, line_len[10:0], frame_lines[10:0],
//               err_cnt[7:0]
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 600,
  parameter int H_ACT_START = 96,
  parameter int H_ACT_LEN   = 640,
  parameter int V_ACT_START = 2,
  parameter int V_ACT_LEN   = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb_in,
  output logic        out_valid,
  output logic        de,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [11:0] rgb_out,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [10:0] C_CNT_MAX     = 11'd2047;
  localparam logic [10:0] C_H_TOTAL     = 11'(H_TOTAL);
  localparam logic [10:0] C_V_TOTAL     = 11'(V_TOTAL);
  localparam logic [10:0] C_H_ACT_START = 11'(H_ACT_START);
  localparam logic [10:0] C_H_ACT_END   = 11'(H_ACT_START + H_ACT_LEN);
  localparam logic [10:0] C_V_ACT_START = 11'(V_ACT_START);
  localparam logic [10:0] C_V_ACT_END   = 11'(V_ACT_START + V_ACT_LEN);

  state_t      r_state;
  logic        r_frame_good;
  logic        r_hs_q;
  logic        r_vs_q;
  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;

  logic        w_h_fall;
  logic        w_v_fall;
  logic [10:0] w_h_inc;
  logic [10:0] w_v_inc;
  logic [10:0] w_h_next;
  logic [10:0] w_v_next;
  logic        w_line_err;
  logic        w_frame_err;
  state_t      w_state_next;
  logic        w_frame_good_next;
  logic        w_err_inc;
  logic        w_de_next;

  // Edge detectors are only meaningful on a strobe; all users gate with pix_en.
  assign w_h_fall = r_hs_q & ~hsync;
  assign w_v_fall = r_vs_q & ~vsync;

  assign w_h_inc  = r_h_cnt + 11'd1;
  assign w_v_inc  = r_v_cnt + 11'd1;

  assign w_h_next = w_h_fall ? 11'd0 :
                    (r_h_cnt == C_CNT_MAX) ? C_CNT_MAX : w_h_inc;
  // A vsync fall restarts the frame even if hsync also falls on this sample.
  assign w_v_next = w_v_fall ? 11'd0 :
                    !w_h_fall ? r_v_cnt :
                    (r_v_cnt == C_CNT_MAX) ? C_CNT_MAX : w_v_inc;

  // Wrong-length line at its closing edge, or overrun flagged exactly once
  // at the sample that carries h_cnt up to H_TOTAL.
  assign w_line_err  = w_h_fall ? (w_h_inc != C_H_TOTAL) : (w_h_inc == C_H_TOTAL);
  assign w_frame_err = w_v_fall && (w_v_inc != C_V_TOTAL);

  always_comb begin
    w_state_next      = r_state;
    w_frame_good_next = r_frame_good;
    w_err_inc         = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_v_fall) begin
          w_state_next      = CHECK;
          w_frame_good_next = 1'b1;
        end
      end
      CHECK: begin
        if (w_v_fall) begin
          // The hsync fall sharing this sample closes the checked frame.
          if (r_frame_good && !w_frame_err && !w_line_err) begin
            w_state_next = LOCKED;
          end
          w_frame_good_next = 1'b1;
        end else if (w_line_err) begin
          w_frame_good_next = 1'b0;
        end
      end
      LOCKED: begin
        if (w_line_err || w_frame_err) begin
          w_state_next = SEARCH;
          w_err_inc    = 1'b1;
        end
      end
      default: w_state_next = SEARCH;
    endcase
  end

  assign w_de_next = (w_state_next == LOCKED) &&
                     (w_h_next >= C_H_ACT_START) && (w_h_next < C_H_ACT_END) &&
                     (w_v_next >= C_V_ACT_START) && (w_v_next < C_V_ACT_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SEARCH;
      r_frame_good <= 1'b0;
      r_hs_q       <= 1'b0;
      r_vs_q       <= 1'b0;
      r_h_cnt      <= 11'd0;
      r_v_cnt      <= 11'd0;
      out_valid    <= 1'b0;
      de           <= 1'b0;
      px_x         <= 10'd0;
      px_y         <= 10'd0;
      rgb_out      <= 12'd0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      line_len     <= 11'd0;
      frame_lines  <= 11'd0;
      err_cnt      <= 8'd0;
    end else if (pix_en) begin
      r_state      <= w_state_next;
      r_frame_good <= w_frame_good_next;
      r_hs_q       <= hsync;
      r_vs_q       <= vsync;
      r_h_cnt      <= w_h_next;
      r_v_cnt      <= w_v_next;
      out_valid    <= 1'b1;
      de           <= w_de_next;
      px_x         <= w_de_next ? 10'(w_h_next - C_H_ACT_START) : 10'd0;
      px_y         <= w_de_next ? 10'(w_v_next - C_V_ACT_START) : 10'd0;
      rgb_out      <= rgb_in;
      frame_start  <= w_v_fall;
      locked       <= (w_state_next == LOCKED);
      if (w_h_fall) begin
        line_len <= w_h_inc;
      end
      if (w_v_fall) begin
        frame_lines <= w_v_inc;
      end
      if (w_err_inc && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end else begin
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_decoder
// Purpose  : Self-checking bench for vga_sync_decoder on a reduced 20x10
//            raster. A behavioural model predicts every output each cycle;
//            literal expectations pin lock, coordinates and error counting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_decoder;

  localparam int HT  = 20;
  localparam int VT  = 10;
  localparam int HAS = 4;
  localparam int HAL = 12;
  localparam int VAS = 2;
  localparam int VAL = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb_in;
  logic        out_valid;
  logic        de;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic [11:0] rgb_out;
  logic        frame_start;
  logic        locked;
  logic [10:0] line_len;
  logic [10:0] frame_lines;
  logic [7:0]  err_cnt;

  int checks   = 0;
  int failures = 0;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACT_LEN(HAL),
    .V_ACT_START(VAS), .V_ACT_LEN(VAL)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .rgb_in(rgb_in), .out_valid(out_valid), .de(de), .px_x(px_x), .px_y(px_y),
    .rgb_out(rgb_out), .frame_start(frame_start), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 searching, 1 qualifying a frame, 2 locked
  int m_phs, m_pvs, m_h, m_v, m_mode, m_good;
  int e_valid, e_de, e_px, e_py, e_rgb, e_fs, e_locked, e_ll, e_fl, e_err;

  always @(posedge clk) begin
    if (reset) begin
      m_phs = 0; m_pvs = 0; m_h = 0; m_v = 0; m_mode = 0; m_good = 0;
      e_valid = 0; e_de = 0; e_px = 0; e_py = 0; e_rgb = 0; e_fs = 0;
      e_locked = 0; e_ll = 0; e_fl = 0; e_err = 0;
    end else if (pix_en) begin
      int hf, vf, lerr, ferr, nh, nv;
      hf = (m_phs == 1 && hsync == 1'b0) ? 1 : 0;
      vf = (m_pvs == 1 && vsync == 1'b0) ? 1 : 0;
      m_phs = int'(hsync);
      m_pvs = int'(vsync);
      lerr = hf ? int'(m_h + 1 != HT) : int'(m_h + 1 == HT);
      ferr = vf && (m_v + 1 != VT);
      if (hf) e_ll = (m_h + 1) % 2048;
      if (vf) e_fl = (m_v + 1) % 2048;
      nh = hf ? 0 : (m_h + 1 > 2047 ? 2047 : m_h + 1);
      nv = vf ? 0 : (hf ? (m_v + 1 > 2047 ? 2047 : m_v + 1) : m_v);
      if (m_mode == 0) begin
        if (vf) begin m_mode = 1; m_good = 1; end
      end else if (m_mode == 1) begin
        if (vf) begin
          if (m_good && !ferr && !lerr) m_mode = 2;
          m_good = 1;
        end else if (lerr) m_good = 0;
      end else begin
        if (lerr || ferr) begin
          m_mode = 0;
          if (e_err < 255) e_err++;
        end
      end
      m_h = nh;
      m_v = nv;
      e_locked = (m_mode == 2);
      e_de = e_locked && nh >= HAS && nh < HAS + HAL && nv >= VAS && nv < VAS + VAL;
      e_px = e_de ? nh - HAS : 0;
      e_py = e_de ? nv - VAS : 0;
      e_rgb = int'(rgb_in);
      e_valid = 1;
      e_fs = vf;
    end else begin
      e_valid = 0;
      e_fs = 0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("de", 32'(de), 32'(e_de));
    chk("px_x", 32'(px_x), 32'(e_px));
    chk("px_y", 32'(px_y), 32'(e_py));
    chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("locked", 32'(locked), 32'(e_locked));
    chk("line_len", 32'(line_len), 32'(e_ll));
    chk("frame_lines", 32'(frame_lines), 32'(e_fl));
    chk("err_cnt", 32'(err_cnt), 32'(e_err));
  end

  // ---------------- stimulus ----------------
  task automatic sample(input bit hs, input bit vs, input logic [11:0] rgb);
    int gap = $urandom_range(0, 3);
    repeat (gap) begin
      @(negedge clk);
      pix_en = 1'b0;
    end
    @(negedge clk);
    pix_en = 1'b1;
    hsync  = hs;
    vsync  = vs;
    rgb_in = rgb;
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_de"}, 32'(de), 0);
    chk({tag, "_px_x"}, 32'(px_x), 0);
    chk({tag, "_px_y"}, 32'(px_y), 0);
    chk({tag, "_rgb_out"}, 32'(rgb_out), 0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_line_len"}, 32'(line_len), 0);
    chk({tag, "_frame_lines"}, 32'(frame_lines), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
  endtask

  // pin_mode 1: coordinate/lock pins; 2: first sample closes an 11-line frame
  task automatic do_frame(input int nlines, input int short_v, input int short_len,
                          input int pin_mode, input int exp_err);
    for (int v = 0; v < nlines; v++) begin
      int len = (v == short_v) ? short_len : HT;
      for (int h = 0; h < len; h++) begin
        logic [11:0] rgb;
        rgb = (pin_mode == 1 && v == 2 && h == 4) ? 12'hABC : 12'($urandom);
        sample(h >= 3, v >= 2, rgb);
        if (pin_mode == 1 && v == 2 && h == 4) begin
          chk("pin_locked", 32'(locked), 1);
          chk("pin_de_first", 32'(de), 1);
          chk("pin_px_x_first", 32'(px_x), 0);
          chk("pin_px_y_first", 32'(px_y), 0);
          chk("pin_rgb_abc", 32'(rgb_out), 32'h0ABC);
          chk("pin_line_len", 32'(line_len), HT);
          chk("pin_frame_lines", 32'(frame_lines), VT);
          chk("pin_err_cnt", 32'(err_cnt), 32'(exp_err));
        end
        if (pin_mode == 1 && v == 7 && h == 15) begin
          chk("pin_de_last", 32'(de), 1);
          chk("pin_px_x_last", 32'(px_x), HAL - 1);
          chk("pin_px_y_last", 32'(px_y), VAL - 1);
        end
        if (pin_mode == 1 && v == 7 && h == 16)
          chk("pin_de_after", 32'(de), 0);
        if (pin_mode == 2 && v == 0 && h == 0) begin
          chk("pin_long_frame_locked", 32'(locked), 0);
          chk("pin_long_frame_lines", 32'(frame_lines), 11);
          chk("pin_long_frame_start", 32'(frame_start), 1);
        end
        if (short_v >= 0 && v == short_v && h == len - 1)
          chk("pin_before_short_locked", 32'(locked), 1);
        if (short_v >= 0 && v == short_v + 1 && h == 0) begin
          chk("pin_short_locked", 32'(locked), 0);
          chk("pin_short_err_cnt", 32'(err_cnt), 32'(exp_err));
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pix_en = 1'b0; hsync = 1'b0; vsync = 1'b0; rgb_in = 12'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Acquire lock, then pin coordinates on a locked frame.
    repeat (3) do_frame(VT, -1, 0, 0, 0);
    do_frame(VT, -1, 0, 1, 0);

    // Short line drops lock; relock after clean frames.
    do_frame(VT, 4, 19, 0, 1);
    do_frame(VT, -1, 0, 0, 0);
    do_frame(VT, -1, 0, 1, 1);

    // Overrun: two clean lines, then hsync held high.
    for (int v = 0; v < 2; v++)
      for (int h = 0; h < HT; h++) begin
        sample(h >= 3, 1'b0, 12'($urandom));
        if (v == 0 && h == 0) chk("overrun_pre_locked", 32'(locked), 1);
      end
    for (int i = 0; i < 25; i++) begin
      sample(1'b1, 1'b1, 12'($urandom));
      if (i == 0) begin
        chk("overrun_locked", 32'(locked), 0);
        chk("overrun_err_cnt", 32'(err_cnt), 2);
        chk("overrun_line_len", 32'(line_len), HT);
      end
    end

    // 11-line frame while qualifying, then clean frame locks.
    do_frame(11, -1, 0, 0, 0);
    do_frame(VT, -1, 0, 2, 0);
    do_frame(VT, -1, 0, 1, 2);

    // Random sync noise, model-checked.
    for (int i = 0; i < 300; i++)
      sample($urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0, 12'($urandom));
    repeat (3) do_frame(VT, -1, 0, 0, 0);

    // Reset mid-frame with both syncs low.
    sample(1'b0, 1'b0, 12'h123);
    sample(1'b0, 1'b0, 12'h456);
    @(negedge clk);
    reset = 1'b1; pix_en = 1'b1; hsync = 1'b0; vsync = 1'b0;
    @(posedge clk);
    #2;
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample(1'b0, 1'b0, 12'($urandom));
      chk("midreset_no_frame_start", 32'(frame_start), 0);
      chk("midreset_no_lock", 32'(locked), 0);
    end
    repeat (2) do_frame(VT, -1, 0, 0, 0);
    do_frame(VT, -1, 0, 1, 0);

    @(negedge clk);
    pix_en = 1'b0;
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
